// File: rtl/aes_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module   : aes_decrypt_iter (with leaf aes_inv_sbox)
//  Purpose  : Iterative AES-128 inverse cipher, one inverse round per clock,
//             driven by a start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Inverse S-box leaf: inverse affine transform followed by GF(2^8) inversion.
// ----------------------------------------------------------------------------
module aes_inv_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_aff;
    logic [7:0] w_inv;
    logic [7:0] w_q;

    assign w_aff = {i_a[6:0], i_a[7]} ^ {i_a[4:0], i_a[7:5]} ^ {i_a[1:0], i_a[7:2]} ^ 8'h05;

    // x^254 is the multiplicative inverse and maps 0 to 0
    always_comb begin
        w_inv = gf_mul(w_aff, w_aff);
        w_q   = 8'h00;
        for (int i = 0; i < 6; i++) begin
            w_q   = gf_mul(w_inv, w_aff);
            w_inv = gf_mul(w_q, w_q);
        end
    end

    assign o_y = w_inv;

endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module aes_decrypt_iter #(
    parameter bit REGISTER_KEY = 1'b1
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            start,
    input  logic [1407:0]   key,
    input  logic [127:0]    cipher_data,
    output logic            busy,
    output logic            done,
    output logic [127:0]    plain_data
);

    localparam logic [3:0] c_FIRST_CNT = 4'd9;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ROUND = 1'b1
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        return {b0, b1, b2, b3};
    endfunction

    state_t         r_fsm;
    logic [3:0]     r_cnt;
    logic [127:0]   r_state;
    logic [127:0]   r_plain;
    logic           r_done;
    logic           r_busy;

    state_t         w_fsm_nxt;
    logic [3:0]     w_cnt_nxt;
    logic [127:0]   w_state_nxt;
    logic [127:0]   w_plain_nxt;
    logic           w_done_nxt;
    logic           w_busy_nxt;
    logic           w_key_load;

    logic [1407:0]  w_key;
    logic [127:0]   w_rk_arr [0:15];
    logic [127:0]   w_rk;
    logic [127:0]   w_sub;
    logic [127:0]   w_t;
    logic [127:0]   w_mix;

    generate
        if (REGISTER_KEY) begin : g_key_reg
            logic [1407:0] r_key;
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_key <= '0;
                end else if (w_key_load) begin
                    r_key <= key;
                end
            end
            assign w_key = r_key;
        end else begin : g_key_direct
            assign w_key = key;
        end
    endgenerate

    // Power-of-two table so the 4-bit round counter indexes it directly
    generate
        for (genvar i = 0; i < 16; i++) begin : g_rk
            if (i <= 10) begin : g_used
                assign w_rk_arr[i] = w_key[1407-128*i -: 128];
            end else begin : g_unused
                assign w_rk_arr[i] = '0;
            end
        end
    endgenerate

    assign w_rk = w_rk_arr[r_cnt];

    // InvShiftRows folded into the S-box wiring: row r rotates right by r
    generate
        for (genvar idx = 0; idx < 16; idx++) begin : g_sbox
            localparam int c_ROW = idx % 4;
            localparam int c_COL = idx / 4;
            localparam int c_SRC = 4 * ((c_COL + 4 - c_ROW) % 4) + c_ROW;
            aes_inv_sbox u_sbox (
                .i_a (r_state[127-8*c_SRC -: 8]),
                .o_y (w_sub[127-8*idx -: 8])
            );
        end
    endgenerate

    assign w_t = w_sub ^ w_rk;

    generate
        for (genvar c = 0; c < 4; c++) begin : g_mix
            assign w_mix[127-32*c -: 32] = inv_mix_col(w_t[127-32*c -: 32]);
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_fsm   <= S_IDLE;
            r_cnt   <= 4'd0;
            r_state <= '0;
            r_plain <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
            r_plain <= w_plain_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        w_plain_nxt = r_plain;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = r_busy;
        w_key_load  = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (start) begin
                    // Initial AddRoundKey uses the port: the key register loads on this same edge
                    w_state_nxt = cipher_data ^ key[127:0];
                    w_cnt_nxt   = c_FIRST_CNT;
                    w_key_load  = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_fsm_nxt   = S_ROUND;
                end
            end
            S_ROUND: begin
                if (r_cnt != 4'd0) begin
                    w_state_nxt = w_mix;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end else begin
                    w_plain_nxt = w_t;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_fsm_nxt   = S_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign plain_data = r_plain;

endmodule

`default_nettype wire

// File: tb/tb_aes_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_decrypt_iter
//  Purpose  : Bench for aes_decrypt_iter; expected plaintexts come from a
//             forward AES-128 model that produces every ciphertext driven.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_decrypt_iter;

    localparam logic [127:0] c_FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_LOOP_KEY = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] c_LOOP_PT  = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] c_LOOP_CT  = 128'h29C3505F571420F6402299B31A02D73A;

    logic           clk = 1'b0;
    logic           n_rst;
    logic           start;
    logic [1407:0]  key;
    logic [127:0]   cipher_data;
    logic           busy;
    logic           done;
    logic [127:0]   plain_data;

    logic [127:0]   drv_plain;
    logic [7:0]     sbox_t [0:255];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;

    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic [127:0]   m_plain = '0;
    logic [127:0]   m_res = '0;
    int             m_end = 0;
    int             m_acc_cyc = 0;

    aes_decrypt_iter #(.REGISTER_KEY(1'b1)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .key         (key),
        .cipher_data (cipher_data),
        .busy        (busy),
        .done        (done),
        .plain_data  (plain_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from first principles: brute-force inverse, then affine map
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[a] = s;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [127:0]  kk;
        logic [1407:0] ks;
        kk = k;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) begin
            w[i] = kk[127:96];
            kk = kk << 32;
        end
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]] ^ rc, sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        ks = '0;
        for (int i = 0; i < 44; i++) ks = {ks[1375:0], w[i]};
        return ks;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] ks);
        logic [7:0]    s [0:15];
        logic [7:0]    t [0:15];
        logic [7:0]    a0, a1, a2, a3;
        logic [127:0]  v;
        logic [1407:0] sh;
        v = pt;
        for (int i = 0; i < 16; i++) begin
            s[i] = v[127:120];
            v = v << 8;
        end
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++)
                        s[4*c+row] = t[4*((c+row)%4)+row];
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                        s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                    end
                end
            end
            sh = ks << (128 * r);
            v = sh[1407:1280];
            for (int i = 0; i < 16; i++) begin
                s[i] = s[i] ^ v[127:120];
                v = v << 8;
            end
        end
        v = '0;
        for (int i = 0; i < 16; i++) v = {v[119:0], s[i]};
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level model: accept when idle, complete ten edges later
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_plain <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (cyc + 1 == m_end) begin
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_plain <= m_res;
                end
            end else if (start) begin
                m_busy    <= 1'b1;
                m_end     <= cyc + 11;
                m_acc_cyc <= cyc + 1;
                m_res     <= drv_plain;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {127'd0, busy}, {127'd0, m_busy});
        chk("done", {127'd0, done}, {127'd0, m_done});
        chk("plain_data", plain_data, m_plain);
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [127:0] k128, input logic [127:0] pt, input logic st);
        logic [1407:0] ks;
        ks          = expand(k128);
        key         = ks;
        cipher_data = encrypt(pt, ks);
        drv_plain   = pt;
        start       = st;
    endtask

    task automatic wait_done(input int limit);
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < limit && done_cnt == n0; i++) step();
        chk("done_timeout", {127'd0, done_cnt != n0}, 128'd1);
    endtask

    initial begin
        logic [1407:0] ks;
        logic [127:0]  pa;
        logic [127:0]  ka;
        int            bcnt;
        int            d0;
        int            first_done;
        int            hold;

        n_rst       = 1'b1;
        start       = 1'b0;
        key         = '0;
        cipher_data = '0;
        drv_plain   = '0;
        #1;
        n_rst = 1'b0;

        build_sbox();
        chk("model_sbox_00", {120'd0, sbox_t[8'h00]}, 128'h63);
        chk("model_sbox_53", {120'd0, sbox_t[8'h53]}, 128'hed);
        ks = expand(c_FIPS_KEY);
        chk("model_ks_last", ks[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model_enc_fips", encrypt(c_FIPS_PT, ks), c_FIPS_CT);
        chk("model_enc_loop", encrypt(c_LOOP_PT, expand(c_LOOP_KEY)), c_LOOP_CT);

        repeat (2) step();
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_done", {127'd0, done}, 128'd0);
        chk("reset_plain", plain_data, 128'd0);
        n_rst = 1'b1;
        step();

        // FIPS vector; key and cipher are trashed right after acceptance
        drive(c_FIPS_KEY, c_FIPS_PT, 1'b1);
        step();
        start       = 1'b0;
        key         = '1;
        cipher_data = rand128();
        wait_done(20);
        chk("fips_latency", 128'(last_done_cyc - m_acc_cyc), 128'd10);
        chk("fips_plain", plain_data, c_FIPS_PT);

        // Loopback vector, then FIPS launched in its done cycle
        step();
        drive(c_LOOP_KEY, c_LOOP_PT, 1'b1);
        bcnt = 0;
        first_done = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            start = 1'b0;
            if (done) begin
                first_done = cyc;
                break;
            end
            if (busy) bcnt++;
        end
        chk("loop_busy_cycles", 128'(bcnt), 128'd10);
        chk("loop_seen_done", {127'd0, first_done >= 0}, 128'd1);
        chk("loop_plain", plain_data, c_LOOP_PT);
        drive(c_FIPS_KEY, c_FIPS_PT, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            start = 1'b0;
            if (done) break;
            chk("b2b_hold", plain_data, c_LOOP_PT);
        end
        // Acceptance happens on the edge after completion, so the period is 11
        chk("b2b_gap", 128'(cyc - first_done), 128'd11);
        chk("b2b_plain", plain_data, c_FIPS_PT);

        // Start while busy is ignored
        repeat (2) step();
        ka = rand128();
        pa = rand128();
        d0 = done_cnt;
        drive(ka, pa, 1'b1);
        step();
        start = 1'b0;
        repeat (3) step();
        drive(rand128(), rand128(), 1'b1);
        step();
        start = 1'b0;
        repeat (15) step();
        chk("busy_start_pulses", 128'(done_cnt - d0), 128'd1);
        chk("busy_start_plain", plain_data, pa);

        // Asynchronous reset in the middle of an operation
        drive(c_FIPS_KEY, c_FIPS_PT, 1'b1);
        step();
        start = 1'b0;
        repeat (5) step();
        n_rst = 1'b0;
        #1;
        chk("midrst_busy", {127'd0, busy}, 128'd0);
        chk("midrst_done", {127'd0, done}, 128'd0);
        chk("midrst_plain", plain_data, 128'd0);
        step();
        n_rst = 1'b1;
        d0 = done_cnt;
        repeat (15) step();
        chk("midrst_no_done", 128'(done_cnt - d0), 128'd0);
        drive(c_FIPS_KEY, c_FIPS_PT, 1'b1);
        step();
        start = 1'b0;
        wait_done(20);
        chk("midrst_restart_plain", plain_data, c_FIPS_PT);

        // Randomised traffic: held starts, re-drives while busy, input trashing
        for (int n = 0; n < 30; n++) begin
            drive(rand128(), rand128(), 1'b1);
            hold = $urandom_range(1, 25);
            for (int i = 0; i < hold; i++) begin
                step();
                if ($urandom_range(0, 3) == 0) drive(rand128(), rand128(), 1'b1);
            end
            start       = 1'b0;
            key         = ~key;
            cipher_data = rand128();
            repeat ($urandom_range(0, 12)) step();
        end
        repeat (15) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
